// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect scheduler for a 5-stage pipeline, state updated on negedge clk
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_index,
  input  logic [4:0]       id_rs2_index,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_index,
  input  logic             ex_wb_sel,
  input  logic             ex_wb_en,
  input  logic             mem_is_branch,
  input  logic             mem_is_jalr,
  input  logic             mem_branch_taken,
  input  logic             mem_guess,
  input  logic             mem_ecall,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_stall,
  output logic             f_d_stall,
  output logic             f_d_flush,
  output logic             d_e_stall,
  output logic             d_e_flush,
  output logic             e_m_stall,
  output logic             e_m_flush,
  output logic             m_w_flush,
  output logic             redirect,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic mispredict, load_use, mem_hold, act, hold, drn, ec, mp, lu;
  assign mispredict = (mem_is_branch & (mem_branch_taken != mem_guess)) | mem_is_jalr;
  assign load_use = ex_wb_sel & ex_wb_en & (ex_rd_index != 5'd0) &
                    ((id_rs1_used & (id_rs1_index == ex_rd_index)) |
                     (id_rs2_used & (id_rs2_index == ex_rd_index)));
  assign mem_hold = dm_req & ~dm_ready;
  // act: RUN rules apply, including the release cycle of a memory wait
  assign act  = rst & (((state == RUN) & ~mem_hold) | ((state == MEM_WAIT) & dm_ready));
  assign hold = rst & (((state == RUN) & mem_hold) | ((state == MEM_WAIT) & ~dm_ready) | (state == HALTED));
  assign drn  = rst & (state == DRAIN);
  assign ec   = act & mem_ecall;
  assign mp   = act & ~mem_ecall & mispredict;
  assign lu   = act & ~mem_ecall & ~mispredict & load_use;
  assign pc_stall  = hold | drn | lu;
  assign f_d_stall = hold | lu;
  assign f_d_flush = ec | mp | drn;
  assign d_e_stall = hold;
  assign d_e_flush = ec | mp | drn | lu;
  assign e_m_stall = hold;
  assign e_m_flush = ec | mp | drn;
  assign m_w_flush = hold;
  assign redirect  = mp;
  assign halted    = rst & (state == HALTED);
  always_ff @(negedge clk) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      drain_cnt    <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (pc_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      case (state)
        RUN: begin
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end else if (mem_ecall) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dm_ready) begin
            state     <= mem_ecall ? DRAIN : RUN;
            drain_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
              state   <= HALTED;
              mem_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= HALTED;
        end
        default: state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random stimulus against a cycle-level reference model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs1_index, id_rs2_index, ex_rd_index;
  logic id_rs1_used, id_rs2_used, ex_wb_sel, ex_wb_en;
  logic mem_is_branch, mem_is_jalr, mem_branch_taken, mem_guess, mem_ecall, dm_req, dm_ready;
  logic pc_stall, f_d_stall, f_d_flush, d_e_stall, d_e_flush, e_m_stall, e_m_flush, m_w_flush;
  logic redirect, halted, mem_err;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;
  bit m_wait, m_drain, m_halt, m_err;
  int m_wcnt, m_dcnt, m_stalls;
  logic [9:0] exp_o;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_index(ex_rd_index), .ex_wb_sel(ex_wb_sel), .ex_wb_en(ex_wb_en),
    .mem_is_branch(mem_is_branch), .mem_is_jalr(mem_is_jalr),
    .mem_branch_taken(mem_branch_taken), .mem_guess(mem_guess),
    .mem_ecall(mem_ecall), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_stall(pc_stall), .f_d_stall(f_d_stall), .f_d_flush(f_d_flush),
    .d_e_stall(d_e_stall), .d_e_flush(d_e_flush), .e_m_stall(e_m_stall),
    .e_m_flush(e_m_flush), .m_w_flush(m_w_flush), .redirect(redirect),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output order: pc_stall f_d_stall f_d_flush d_e_stall d_e_flush e_m_stall e_m_flush m_w_flush redirect halted
  function automatic logic [9:0] expect_out();
    bit hold, mp, lu;
    if (!rst) return 10'b0;
    if (m_halt) return 10'b1101010101;
    if (m_drain) return 10'b1010101000;
    hold = m_wait ? !dm_ready : (dm_req && !dm_ready);
    if (hold) return 10'b1101010100;
    if (mem_ecall) return 10'b0010101000;
    mp = (mem_is_branch && (mem_branch_taken != mem_guess)) || mem_is_jalr;
    if (mp) return 10'b0010101010;
    lu = ex_wb_sel && ex_wb_en && ex_rd_index != 0 &&
         ((id_rs1_used && id_rs1_index == ex_rd_index) || (id_rs2_used && id_rs2_index == ex_rd_index));
    if (lu) return 10'b1100100000;
    return 10'b0;
  endfunction

  task automatic model_update();
    bit hold;
    if (!rst) begin
      m_wait = 0; m_drain = 0; m_halt = 0; m_err = 0; m_wcnt = 0; m_dcnt = 0; m_stalls = 0;
    end else begin
      if (exp_o[9] && m_stalls < 65535) m_stalls++;
      hold = m_wait ? !dm_ready : (dm_req && !dm_ready);
      if (m_halt) begin
      end else if (m_drain) begin
        m_dcnt++;
        if (m_dcnt == 2) begin m_drain = 0; m_halt = 1; end
      end else if (hold) begin
        if (!m_wait) begin m_wait = 1; m_wcnt = 1; end
        else begin
          m_wcnt++;
          if (m_wcnt == 15) begin m_wait = 0; m_halt = 1; m_err = 1; end
        end
      end else begin
        m_wait = 0;
        if (mem_ecall) begin m_drain = 1; m_dcnt = 0; end
      end
    end
  endtask

  task automatic step(input string tag);
    exp_o = expect_out();
    @(posedge clk); #1;
    chk({tag, "/ctl"}, 32'({pc_stall, f_d_stall, f_d_flush, d_e_stall, d_e_flush,
                            e_m_stall, e_m_flush, m_w_flush, redirect, halted}), 32'(exp_o));
    chk({tag, "/cnt"}, 32'(stall_cycles), 32'(m_stalls));
    chk({tag, "/err"}, 32'(mem_err), 32'(m_err));
    @(negedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    rst = 1; id_rs1_index = 0; id_rs2_index = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd_index = 0; ex_wb_sel = 0; ex_wb_en = 0; mem_is_branch = 0; mem_is_jalr = 0;
    mem_branch_taken = 0; mem_guess = 0; mem_ecall = 0; dm_req = 0; dm_ready = 0;
  endtask

  task automatic do_reset();
    clr(); rst = 0; step("reset"); rst = 1;
  endtask

  initial begin
    clr(); rst = 0;
    #1;
    step("reset0");
    step("reset1");
    chk("reset_cnt", 32'(stall_cycles), 32'd0);
    rst = 1;
    ex_rd_index = 5; ex_wb_sel = 1; ex_wb_en = 1; id_rs2_index = 5; id_rs2_used = 1;
    step("load_use");
    chk("lu_count", 32'(stall_cycles), 32'd1);
    clr(); step("lu_after");
    ex_rd_index = 0; ex_wb_sel = 1; ex_wb_en = 1; id_rs2_index = 0; id_rs2_used = 1;
    step("lu_x0");
    ex_rd_index = 5; id_rs2_index = 5; ex_wb_en = 0;
    step("lu_noen");
    ex_wb_en = 1; mem_is_branch = 1; mem_branch_taken = 1; mem_guess = 0;
    step("mispred_lu");
    clr(); mem_is_branch = 1; mem_branch_taken = 1; mem_guess = 1;
    step("pred_ok");
    clr(); mem_is_jalr = 1; step("jalr");
    do_reset();
    dm_req = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) step("dm_wait");
    dm_ready = 1; step("dm_done");
    clr(); step("dm_after");
    chk("dm_count", 32'(stall_cycles), 32'd3);
    do_reset();
    dm_req = 1; dm_ready = 0;
    for (int i = 0; i < 18; i++) step("timeout");
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_halt", 32'(halted), 32'd1);
    clr(); rst = 0; step("to_rst");
    rst = 1; step("to_clear");
    chk("to_err_clr", 32'(mem_err), 32'd0);
    chk("to_halt_clr", 32'(halted), 32'd0);
    mem_ecall = 1; step("ecall");
    clr();
    for (int i = 0; i < 6; i++) step("drain_halt");
    chk("ecall_halt", 32'(halted), 32'd1);
    do_reset();
    mem_ecall = 1; step("ecall2");
    clr(); step("drain1");
    rst = 0; step("drain_rst");
    rst = 1; step("drain_run");
    chk("drain_run_stall", 32'(pc_stall), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      id_rs1_index = 5'($urandom_range(0, 3)); id_rs2_index = 5'($urandom_range(0, 3));
      ex_rd_index = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_wb_sel = 1'($urandom); ex_wb_en = 1'($urandom);
      mem_is_branch = ($urandom_range(0, 3) == 0); mem_is_jalr = ($urandom_range(0, 15) == 0);
      mem_branch_taken = 1'($urandom); mem_guess = 1'($urandom);
      mem_ecall = ($urandom_range(0, 59) == 0);
      dm_req = ($urandom_range(0, 2) == 0); dm_ready = ($urandom_range(0, 3) != 0);
      step("random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
